// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a one-register-per-cycle zero sweep.
// All outputs are registered; le/d_out drive the Register32 LE/D pins directly.
module regfile_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREGS = 16,
  parameter int DW    = 32,
  parameter int AW    = 4
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  input  logic               sweep_req,
  output logic [NREQ-1:0]    gnt,
  output logic [NREGS-1:0]   le,
  output logic [DW-1:0]      d_out,
  output logic               busy,
  output logic               sweep_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);

  logic [0:0]    state;
  logic [PW-1:0] ptr;
  // idx holds the register the next sweep beat will write
  logic [AW-1:0] idx;

  logic [AW-1:0] addr_arr [NREQ];
  logic [DW-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = wr_addr[g*AW +: AW];
    assign data_arr[g] = wr_data[g*DW +: DW];
  end

  logic              found;
  logic [PW-1:0]     win;
  logic [PW-1:0]     ptr_nxt;
  logic [NREQ-1:0]   win_gnt;
  logic [NREGS-1:0]  win_le;
  logic [NREGS-1:0]  idx_le;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_data;

  // Rotating priority search starting at ptr
  always_comb begin
    int unsigned cand;
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      cand = (32'(ptr) + i) % NREQ_U;
      if (!found && req[PW'(cand)]) begin
        found = 1'b1;
        win   = PW'(cand);
      end
    end
  end

  always_comb begin
    win_addr = addr_arr[win];
    win_data = data_arr[win];
    ptr_nxt  = (win == LAST_REQ) ? '0 : win + 1'b1;

    win_gnt      = '0;
    win_gnt[win] = 1'b1;

    // Out-of-range targets still get a grant but no load enable
    win_le = '0;
    if ({1'b0, win_addr} < (AW+1)'(NREGS))
      win_le[win_addr] = 1'b1;

    idx_le      = '0;
    idx_le[idx] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state      <= ST_ARB;
      ptr        <= '0;
      idx        <= '0;
      gnt        <= '0;
      le         <= '0;
      d_out      <= '0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          sweep_done <= 1'b0;
          if (sweep_req) begin
            // Entry edge already presents beat 0 so busy spans exactly NREGS cycles
            state <= ST_SWEEP;
            idx   <= AW'(1);
            gnt   <= '0;
            le    <= NREGS'(1);
            d_out <= '0;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
            if (found) begin
              gnt   <= win_gnt;
              le    <= win_le;
              d_out <= win_data;
              ptr   <= ptr_nxt;
            end else begin
              gnt <= '0;
              le  <= '0;
            end
          end
        end

        ST_SWEEP: begin
          gnt   <= '0;
          le    <= idx_le;
          d_out <= '0;
          busy  <= 1'b1;
          if (idx == LAST_IDX) begin
            sweep_done <= 1'b1;
            state      <= ST_ARB;
            idx        <= '0;
          end else begin
            sweep_done <= 1'b0;
            idx        <= idx + 1'b1;
          end
        end

        default: begin
          state <= ST_ARB;
          gnt   <= '0;
          le    <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a cycle-level reference model queues expected
// outputs, a monitor compares them, and a behavioural register file tracks the writes.
module tb_regfile_write_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 16;
  localparam int DW    = 32;
  localparam int AW    = 4;

  logic               Clk = 1'b0;
  logic               Clr = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] wr_addr = '0;
  logic [NREQ*DW-1:0] wr_data = '0;
  logic               sweep_req = 1'b0;
  logic [NREQ-1:0]    gnt;
  logic [NREGS-1:0]   le;
  logic [DW-1:0]      d_out;
  logic               busy;
  logic               sweep_done;

  always #5 Clk = ~Clk;

  regfile_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Clr(Clr), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .sweep_req(sweep_req), .gnt(gnt), .le(le), .d_out(d_out), .busy(busy),
    .sweep_done(sweep_done)
  );

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [NREGS-1:0] le;
    logic [DW-1:0]    d;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t expq[$];
  int nvec = 0;
  int nerr = 0;

  logic [DW-1:0] rf_dut [NREGS] = '{default: '0};
  logic [DW-1:0] rf_ref [NREGS];

  // Register32 bank driven by the DUT
  always @(posedge Clk)
    for (int r = 0; r < NREGS; r++)
      if (le[r]) rf_dut[r] <= d_out;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep countdown plus rotating priority pointer
  initial begin
    int sweep_left, rr, w, c, beat;
    bit hit;
    logic [AW-1:0] a;
    logic [DW-1:0] last_d;
    exp_t e, pend;
    sweep_left = 0; rr = 0; last_d = '0; pend = '0;
    for (int r = 0; r < NREGS; r++) rf_ref[r] = '0;
    forever begin
      @(posedge Clk or negedge Clr);
      if (!Clr) begin
        sweep_left = 0; rr = 0; last_d = '0; pend = '0;
        expq.delete();
      end else begin
        for (int r = 0; r < NREGS; r++)
          if (pend.le[r]) rf_ref[r] = pend.d;
        e = '0;
        e.d = last_d;
        if (sweep_left == 0 && sweep_req) sweep_left = NREGS;
        if (sweep_left > 0) begin
          beat = NREGS - sweep_left;
          e.le[beat] = 1'b1;
          e.d = '0;
          e.busy = 1'b1;
          e.done = (sweep_left == 1);
          sweep_left--;
        end else begin
          hit = 0; w = 0;
          for (int k = 0; k < NREQ; k++) begin
            c = (rr + k) % NREQ;
            if (!hit && req[c]) begin hit = 1; w = c; end
          end
          if (hit) begin
            e.gnt[w] = 1'b1;
            a = wr_addr[w*AW +: AW];
            if (int'(a) < NREGS) e.le[a] = 1'b1;
            e.d = wr_data[w*DW +: DW];
            rr = (w + 1) % NREQ;
          end
        end
        last_d = e.d;
        pend = e;
        expq.push_back(e);
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (!Clr) begin
        chk("rst_gnt",  32'(gnt), '0);
        chk("rst_le",   32'(le), '0);
        chk("rst_dout", d_out, '0);
        chk("rst_busy", 32'(busy), '0);
        chk("rst_done", 32'(sweep_done), '0);
      end else if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("gnt",   32'(gnt), 32'(e.gnt));
        chk("le",    32'(le), 32'(e.le));
        chk("d_out", d_out, e.d);
        chk("busy",  32'(busy), 32'(e.busy));
        chk("done",  32'(sweep_done), 32'(e.done));
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
  endtask

  task automatic async_reset();
    Clr = 1'b0;
    #1;
    chk("async_gnt",  32'(gnt), '0);
    chk("async_le",   32'(le), '0);
    chk("async_busy", 32'(busy), '0);
    chk("async_dout", d_out, '0);
    step();
    Clr = 1'b1;
  endtask

  initial begin
    #1 Clr = 1'b0;
    req = 4'b1111;
    repeat (3) step();
    req = '0;
    Clr = 1'b1;
    step();

    // Single write to R5
    set_req(2, 4'd5, 32'hDEADBEEF);
    step();
    req = '0;
    step();
    chk("r5_write", rf_dut[5], 32'hDEADBEEF);

    // All requesters contending, then 0 and 3 only
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 8), 32'h1000_0000 + i);
    repeat (8) step();
    req = 4'b1001;
    repeat (4) step();
    req = '0;
    step();

    // Preload all ones, then sweep
    for (int r = 0; r < NREGS; r++) begin
      set_req(0, AW'(r), 32'hFFFFFFFF);
      step();
    end
    req = '0;
    step();
    sweep_req = 1'b1;
    step();
    sweep_req = 1'b0;
    repeat (18) step();
    for (int r = 0; r < NREGS; r++) chk("sweep_zero", rf_dut[r], '0);

    // Sweep beats a simultaneous request; requester 1 waits it out
    sweep_req = 1'b1;
    set_req(1, 4'd7, 32'hA5A5_0001);
    step();
    sweep_req = 1'b0;
    repeat (16) step();
    req = '0;
    step();

    // Back-to-back grants to requester 1
    set_req(1, 4'd3, 32'h0000_0003);
    step();
    set_req(1, 4'd4, 32'h0000_0004);
    step();
    set_req(1, 4'd5, 32'h0000_0005);
    step();
    req = '0;
    step();

    // Reset mid-sweep
    sweep_req = 1'b1;
    step();
    sweep_req = 1'b0;
    repeat (5) step();
    async_reset();
    repeat (3) step();

    // Randomised traffic with handshake-respecting requesters
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom_range(0, 1) == 1) set_req(i, AW'($urandom), $urandom);
          else req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 29) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          set_req(i, AW'($urandom), $urandom);
        end
      end
      sweep_req = ($urandom_range(0, 149) == 0);
      if (n == 1000) async_reset();
      step();
    end
    req = '0;
    sweep_req = 1'b0;
    repeat (20) step();

    for (int r = 0; r < NREGS; r++) chk("rf_final", rf_dut[r], rf_ref[r]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
